periph_arbiter: RTL
===================

PERIPH_ARBITER -- requirements
Module: periph_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, cycles to wait for s_ack before forced completion (used only with PERIPH_ARB_TIMEOUT_EN).
REQ-002 clock  in  1  system clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 mN_request  in  1  master N (N=0,1) single-cycle transaction pulse.
REQ-005 mN_addr  in  16  master N register address.
REQ-006 mN_write  in  1  1 = write, 0 = read.
REQ-007 mN_byte_enable  in  4  byte lanes for write.
REQ-008 mN_wdata  in  32  write data.
REQ-009 mN_rdata  out  32  read data, valid when mN_ack high.
REQ-010 mN_ack  out  1  single-cycle completion pulse to master N.
REQ-011 s_request, s_addr[16], s_write, s_byte_enable[4], s_wdata[32]  out  to the hardware-register block; s_request single-cycle pulse.
REQ-012 s_rdata  in  32;  s_ack  in  1  register-block response, s_ack single-cycle.

Function
REQ-013 Each master SHALL have one pending slot; mN_request high captures addr/write/byte_enable/wdata into slot N and sets pending N.
REQ-014 mN_request while slot N already pending SHALL be ignored (slot contents unchanged).
REQ-015 FSM states SHALL be IDLE and WAIT; only one downstream transaction outstanding at any time.
REQ-016 IDLE: if any slot pending, or any mN_request this cycle, SHALL grant one master, register its fields onto s_*, pulse s_request next cycle, go WAIT.
REQ-017 Arbitration SHALL be round-robin: single contender wins; with both contending, master not granted last wins; after reset master 0 wins first tie.
REQ-018 WAIT: on s_ack high, SHALL clear granted slot, register s_rdata to granted mN_rdata, pulse granted mN_ack next cycle, return to IDLE.
REQ-019 Idle-arbiter latency: mN_request at cycle T -> s_request at T+1; s_ack at T+2 -> mN_ack at T+3.
REQ-020 Back-to-back: new grant SHALL be possible in the cycle following the s_ack cycle (no extra idle cycle).
REQ-021 Request from the granted master arriving in the s_ack cycle SHALL be captured into its now-free slot.
REQ-022 s_ack in IDLE SHALL be ignored.
REQ-023 mN_rdata SHALL be 0 whenever mN_ack is low; s_wdata/s_addr hold last value when s_request low.
REQ-024 Write transactions SHALL return ack identically to reads, mN_rdata = s_rdata as returned.

Reset
REQ-025 Reset SHALL force IDLE, clear both pending slots, last-grant = master 1, all outputs 0, timeout counter 0.
REQ-026 Reset during WAIT SHALL abandon the transaction; no mN_ack issued; later s_ack ignored.

Configuration
REQ-027 Macro PERIPH_ARB_TIMEOUT_EN defined: WAIT counts cycles; if TIMEOUT_CYCLES elapse without s_ack, SHALL pulse granted mN_ack with mN_rdata = 32'hDEADBEEF, clear slot, return IDLE.
REQ-028 Macro undefined: no counter; WAIT persists until s_ack.

Structure
REQ-029 Package periph_arb_pkg SHALL hold the FSM state enum and TIMEOUT_RDATA constant (32'hDEADBEEF).
REQ-030 Sub-module periph_arb_slot (pending capture for one master) SHALL be instantiated twice.

Verification
REQ-031 m0 read addr 0x0008, slave acks 1 cycle after s_request with 0x000002A5 -> m0_ack at T+3, m0_rdata 0x000002A5.
REQ-032 m0 and m1 request same cycle after reset -> m0 served first, m1 s_request in cycle after m0's s_ack.
REQ-033 Both masters re-request continuously -> grants alternate m0,m1,m0,m1 over 4 transactions.
REQ-034 m1 write 0x0004 data 0x3FF, then second m1_request before ack -> only one s_request, s_wdata 0x3FF.
REQ-035 With PERIPH_ARB_TIMEOUT_EN, slave never acks -> m0_ack 16 cycles into WAIT, m0_rdata 0xDEADBEEF; late s_ack ignored.
REQ-036 Reset asserted in WAIT -> no mN_ack, all outputs 0, next request served normally.

Source files
------------

// File: rtl/periph_arb_pkg.sv
// periph_arb_pkg: shared types and constants for the two-master register-bus
// arbiter.
//   state_t        - arbiter FSM states (IDLE, WAIT)
//   req_fields_t   - captured fields of one master transaction
//   TIMEOUT_RDATA  - read data returned when a transaction is force-completed
//   pack_fields()  - bundles the loose request fields into a req_fields_t
package periph_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

    typedef struct packed {
        logic [15:0] addr;
        logic        write;
        logic [3:0]  byte_enable;
        logic [31:0] wdata;
    } req_fields_t;

    function automatic req_fields_t pack_fields(
        input logic [15:0] addr,
        input logic        write,
        input logic [3:0]  byte_enable,
        input logic [31:0] wdata
    );
        req_fields_t f;
        f.addr        = addr;
        f.write       = write;
        f.byte_enable = byte_enable;
        f.wdata       = wdata;
        return f;
    endfunction

endpackage

// File: rtl/periph_arb_if.sv
// periph_arb_if: every bus signal between the two masters, the arbiter and the
// hardware-register block.
//   mN_*  - master N request side (request pulse, addr, write, byte_enable,
//           wdata) and response side (rdata, ack pulse)
//   s_*   - downstream register-block request and response
// Modports:
//   slave  - the arbiter's view (serves the masters, drives the register block)
//   master - the environment's view (masters plus register block)
interface periph_arb_if;

    logic        m0_request;
    logic [15:0] m0_addr;
    logic        m0_write;
    logic [3:0]  m0_byte_enable;
    logic [31:0] m0_wdata;
    logic [31:0] m0_rdata;
    logic        m0_ack;

    logic        m1_request;
    logic [15:0] m1_addr;
    logic        m1_write;
    logic [3:0]  m1_byte_enable;
    logic [31:0] m1_wdata;
    logic [31:0] m1_rdata;
    logic        m1_ack;

    logic        s_request;
    logic [15:0] s_addr;
    logic        s_write;
    logic [3:0]  s_byte_enable;
    logic [31:0] s_wdata;
    logic [31:0] s_rdata;
    logic        s_ack;

    modport slave (
        input  m0_request, m0_addr, m0_write, m0_byte_enable, m0_wdata,
        output m0_rdata, m0_ack,
        input  m1_request, m1_addr, m1_write, m1_byte_enable, m1_wdata,
        output m1_rdata, m1_ack,
        output s_request, s_addr, s_write, s_byte_enable, s_wdata,
        input  s_rdata, s_ack
    );

    modport master (
        output m0_request, m0_addr, m0_write, m0_byte_enable, m0_wdata,
        input  m0_rdata, m0_ack,
        output m1_request, m1_addr, m1_write, m1_byte_enable, m1_wdata,
        input  m1_rdata, m1_ack,
        input  s_request, s_addr, s_write, s_byte_enable, s_wdata,
        output s_rdata, s_ack
    );

endinterface

// File: rtl/periph_arb_slot.sv
// periph_arb_slot: one-deep pending slot for a single master.
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   req_i         - master request pulse
//   fields_i      - master request fields
//   clear_i       - the transaction held in this slot completes this cycle
//   pending_o     - slot occupied (waiting or in flight)
//   fields_o      - captured fields
// A request is ignored while the slot is occupied, except in the completion
// cycle, where the freed slot immediately takes the new request.
module periph_arb_slot
    import periph_arb_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_i,
    input  req_fields_t fields_i,
    input  logic        clear_i,
    output logic        pending_o,
    output req_fields_t fields_o
);

    logic        pending_q;
    logic        pending_d;
    req_fields_t fields_q;
    req_fields_t fields_d;
    logic        capture_s;

    assign capture_s = req_i && (!pending_q || clear_i);

    // Next-state for occupancy and captured fields.
    always_comb begin
        pending_d = pending_q;
        fields_d  = fields_q;
        if (capture_s) begin
            pending_d = 1'b1;
            fields_d  = fields_i;
        end else if (clear_i) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    // Slot state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q <= 1'b0;
            fields_q  <= '0;
        end else begin
            pending_q <= pending_d;
            fields_q  <= fields_d;
        end
    end

    assign pending_o = pending_q;
    assign fields_o  = fields_q;

endmodule

// File: rtl/periph_arbiter.sv
// periph_arbiter: round-robin arbiter giving two masters single-outstanding
// access to a hardware-register block.
// Ports:
//   clock, reset - rising-edge clock, synchronous active-high reset
//   bus          - periph_arb_if.slave (master request/response, register
//                  block request/response)
// Parameter TIMEOUT_CYCLES: WAIT cycles before forced completion; only has an
// effect when the macro PERIPH_ARB_TIMEOUT_EN is defined. Without that macro
// WAIT lasts until s_ack.
// A completion cycle (s_ack or timeout) may immediately grant the next
// contender, so back-to-back transactions need no idle cycle.
module periph_arbiter
    import periph_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    periph_arb_if.slave bus
);

    state_t      state_q;
    logic        gnt_q;          // last granted master = owner while in WAIT
    logic        s_request_q;
    logic [15:0] s_addr_q;
    logic        s_write_q;
    logic [3:0]  s_be_q;
    logic [31:0] s_wdata_q;
    logic        m0_ack_q;
    logic        m1_ack_q;
    logic [31:0] m0_rdata_q;
    logic [31:0] m1_rdata_q;

    logic        pend0_s, pend1_s;
    req_fields_t slot0_s, slot1_s, live0_s, live1_s, win_s;
    logic        timeout_s, done_s, clear0_s, clear1_s;
    logic        avail0_s, avail1_s, pick_s, grant_s;
    logic [31:0] done_rdata_s;

    assign live0_s = pack_fields(bus.m0_addr, bus.m0_write, bus.m0_byte_enable, bus.m0_wdata);
    assign live1_s = pack_fields(bus.m1_addr, bus.m1_write, bus.m1_byte_enable, bus.m1_wdata);

`ifdef PERIPH_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q;

    assign timeout_s = (state_q == ST_WAIT) && (cnt_q == CNT_LAST);

    // WAIT-cycle counter, restarted by every grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (grant_s) begin
            cnt_q <= '0;
        end else if (state_q == ST_WAIT) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end
`else
    // The parameter is inert in this build; expiry is tied off.
    assign timeout_s = (TIMEOUT_CYCLES < 32'sd0);
`endif

    assign done_s       = (state_q == ST_WAIT) && (bus.s_ack || timeout_s);
    assign clear0_s     = done_s && (gnt_q == 1'b0);
    assign clear1_s     = done_s && (gnt_q == 1'b1);
    assign done_rdata_s = bus.s_ack ? bus.s_rdata : TIMEOUT_RDATA;

    periph_arb_slot u_slot0 (
        .clock     (clock),
        .reset     (reset),
        .req_i     (bus.m0_request),
        .fields_i  (live0_s),
        .clear_i   (clear0_s),
        .pending_o (pend0_s),
        .fields_o  (slot0_s)
    );

    periph_arb_slot u_slot1 (
        .clock     (clock),
        .reset     (reset),
        .req_i     (bus.m1_request),
        .fields_i  (live1_s),
        .clear_i   (clear1_s),
        .pending_o (pend1_s),
        .fields_o  (slot1_s)
    );

    // A waiting slot contends unless it is the one completing now; a live
    // request contends directly so an idle arbiter grants in the same cycle.
    assign avail0_s = (pend0_s && !clear0_s) || bus.m0_request;
    assign avail1_s = (pend1_s && !clear1_s) || bus.m1_request;
    assign grant_s  = (avail0_s || avail1_s) && ((state_q == ST_IDLE) || done_s);

    // Round-robin pick and selection of the winner's fields.
    always_comb begin
        pick_s = 1'b0;
        win_s  = live0_s;
        if (avail0_s && avail1_s) begin
            pick_s = ~gnt_q;
        end else if (avail1_s) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
        if (pick_s) begin
            win_s = (pend1_s && !clear1_s) ? slot1_s : live1_s;
        end else begin
            win_s = (pend0_s && !clear0_s) ? slot0_s : live0_s;
        end
    end

    // Arbiter FSM with registered downstream request and master responses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 1'b1;
            s_request_q <= 1'b0;
            s_addr_q    <= 16'h0000;
            s_write_q   <= 1'b0;
            s_be_q      <= 4'h0;
            s_wdata_q   <= 32'h0000_0000;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            m0_rdata_q  <= 32'h0000_0000;
            m1_rdata_q  <= 32'h0000_0000;
        end else begin
            s_request_q <= grant_s;
            m0_ack_q    <= clear0_s;
            m1_ack_q    <= clear1_s;
            m0_rdata_q  <= clear0_s ? done_rdata_s : 32'h0000_0000;
            m1_rdata_q  <= clear1_s ? done_rdata_s : 32'h0000_0000;
            if (grant_s) begin
                s_addr_q  <= win_s.addr;
                s_write_q <= win_s.write;
                s_be_q    <= win_s.byte_enable;
                s_wdata_q <= win_s.wdata;
                gnt_q     <= pick_s;
            end else begin
                gnt_q     <= gnt_q;
            end
            case (state_q)
                ST_IDLE: begin
                    if (grant_s) begin
                        state_q <= ST_WAIT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (grant_s) begin
                        state_q <= ST_WAIT;
                    end else if (done_s) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.s_request     = s_request_q;
    assign bus.s_addr        = s_addr_q;
    assign bus.s_write       = s_write_q;
    assign bus.s_byte_enable = s_be_q;
    assign bus.s_wdata       = s_wdata_q;
    assign bus.m0_ack        = m0_ack_q;
    assign bus.m1_ack        = m1_ack_q;
    assign bus.m0_rdata      = m0_rdata_q;
    assign bus.m1_rdata      = m1_rdata_q;

endmodule
